multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencing controller (Moore FSM: fetch/decode/execute/memory/write-back).
// Latency: outputs are combinational from state (plus mem_ready and zero); the state advances on each clk edge.
// Backpressure: FETCH, MEMRD and MEMWR hold their strobes and stall until mem_ready=1.
module multicycle_ctrl #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       regwrite,
  output logic       alusrc_a,
  output logic [1:0] alusrc_b,
  output logic [1:0] aluop,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JAL    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  state_t cur_state;
  state_t nxt_state;
  logic   rdy;
  logic   pc_write;
  logic   pc_write_cond;

  // With waits disabled the memory is modelled as single-cycle.
  assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  // State register; reset always lands in FETCH, aborting any instruction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) cur_state <= S_FETCH;
    else        cur_state <= nxt_state;
  end

  // Next-state and Moore outputs; everything is forced low while reset is held.
  always_comb begin
    nxt_state     = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    regdst        = 2'b00;
    memtoreg      = 2'b00;
    regwrite      = 1'b0;
    alusrc_a      = 1'b0;
    alusrc_b      = 2'b00;
    aluop         = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    case (cur_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alusrc_b  = 2'b01;
        nxt_state = S_FETCH;
        if (rdy) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          nxt_state = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrc_b = 2'b11;
        case (opcode)
          OP_RTYPE:        nxt_state = S_EXEC;
          OP_LW, OP_SW:    nxt_state = S_MEMADR;
          OP_ADDI, OP_ANDI: nxt_state = S_IEXEC;
          OP_BEQ:          nxt_state = S_BRANCH;
          OP_JAL:          nxt_state = S_JAL;
          default: begin
            nxt_state = S_FETCH;
            illegal   = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrc_a  = 1'b1;
        alusrc_b  = 2'b10;
        nxt_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read  = 1'b1;
        iord      = 1'b1;
        nxt_state = rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg   = 2'b01;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = rdy;
        nxt_state  = rdy ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alusrc_a  = 1'b1;
        aluop     = 2'b10;
        nxt_state = S_RWB;
      end
      S_RWB: begin
        regdst     = 2'b01;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alusrc_a      = 1'b1;
        aluop         = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_IEXEC: begin
        alusrc_a  = 1'b1;
        alusrc_b  = 2'b10;
        aluop     = (opcode == OP_ANDI) ? 2'b11 : 2'b00;
        nxt_state = S_IWB;
      end
      S_IWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        // PC already holds PC+4 from FETCH, so $31 gets the return address.
        regdst     = 2'b10;
        memtoreg   = 2'b10;
        regwrite   = 1'b1;
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      default: nxt_state = S_FETCH;
    endcase
    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      regdst        = 2'b00;
      memtoreg      = 2'b00;
      regwrite      = 1'b0;
      alusrc_a      = 1'b0;
      alusrc_b      = 2'b00;
      aluop         = 2'b00;
      pc_source     = 2'b00;
      instr_done    = 1'b0;
      illegal       = 1'b0;
    end
  end

  // Branch enable follows the live zero flag in the same cycle.
  assign pc_en = pc_write | (pc_write_cond & zero);
  assign state = rst_n ? cur_state : 4'd0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl.
// A per-instruction model predicts the state trace, control trace and strobe counts.
// A negedge monitor collects observed behaviour and compares on each completion pulse.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, regwrite, alusrc_a;
  logic       instr_done, illegal;
  logic [1:0] regdst, memtoreg, alusrc_b, aluop, pc_source;
  logic [3:0] state;
  logic [22:0] all_out;

  multicycle_ctrl #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .aluop(aluop), .pc_source(pc_source),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  assign all_out = {pc_en, iord, mem_read, mem_write, ir_write, regdst, memtoreg, regwrite,
                    alusrc_a, alusrc_b, aluop, pc_source, instr_done, illegal, state};

  always #5 clk = ~clk;

  typedef struct {
    int          cycles;
    logic [63:0] ssig;
    logic [63:0] csig;
    int          irw, mrd, mwr, pcen, rw;
    logic        ill;
    logic [1:0]  regdst, memtoreg, pc_source;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of behaviour: state code plus {iord, alusrc_a, alusrc_b, aluop}.
  function automatic void add(inout exp_t e, input logic [3:0] st, input logic [5:0] ctl);
    e.ssig = {e.ssig[59:0], st};
    e.csig = {e.csig[57:0], ctl};
    e.cycles++;
  endfunction

  // Reference: what an instruction should look like given its memory waits and zero flag.
  function automatic exp_t build_exp(input logic [5:0] op, input int fw, input int mw, input logic z);
    exp_t e;
    e = '{cycles: 0, ssig: 64'd0, csig: 64'd0, irw: 1, mrd: fw + 1, mwr: 0, pcen: 1, rw: 0,
          ill: 1'b0, regdst: 2'b00, memtoreg: 2'b00, pc_source: 2'b00};
    for (int i = 0; i <= fw; i++) add(e, 4'd0, 6'b000100);
    add(e, 4'd1, 6'b001100);
    case (op)
      OP_RTYPE: begin add(e, 4'd6, 6'b010010); add(e, 4'd7, 6'd0); e.rw = 1; e.regdst = 2'b01; end
      OP_LW: begin
        add(e, 4'd2, 6'b011000);
        for (int i = 0; i <= mw; i++) add(e, 4'd3, 6'b100000);
        add(e, 4'd4, 6'd0);
        e.mrd += mw + 1; e.rw = 1; e.memtoreg = 2'b01;
      end
      OP_SW: begin
        add(e, 4'd2, 6'b011000);
        for (int i = 0; i <= mw; i++) add(e, 4'd5, 6'b100000);
        e.mwr = mw + 1;
      end
      OP_ADDI: begin add(e, 4'd9, 6'b011000); add(e, 4'd10, 6'd0); e.rw = 1; end
      OP_ANDI: begin add(e, 4'd9, 6'b011011); add(e, 4'd10, 6'd0); e.rw = 1; end
      OP_BEQ: begin add(e, 4'd8, 6'b010001); e.pcen += int'(z); e.pc_source = 2'b01; end
      OP_JAL: begin
        add(e, 4'd11, 6'd0);
        e.rw = 1; e.pcen += 1; e.regdst = 2'b10; e.memtoreg = 2'b10; e.pc_source = 2'b10;
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Drive one instruction; mem_ready/zero only matter where the model says they do.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic z);
    exp_t e;
    e = build_exp(op, fw, mw, z);
    sbq.push_back(e);
    for (int i = 0; i < e.cycles; i++) begin
      opcode    = (i <= fw) ? 6'($urandom) : op;
      mem_ready = 1'($urandom);
      zero      = 1'($urandom);
      if (i < fw) mem_ready = 1'b0;
      else if (i == fw) mem_ready = 1'b1;
      if ((op == OP_LW || op == OP_SW) && i >= fw + 3) mem_ready = (i == fw + 3 + mw);
      if (op == OP_BEQ && i == fw + 2) zero = z;
      @(posedge clk); #1;
    end
  endtask

  int          m_cyc = 0, m_irw = 0, m_mrd = 0, m_mwr = 0, m_pcen = 0, m_rw = 0;
  logic [63:0] m_ssig = 64'd0, m_csig = 64'd0;
  exp_t        m_e;

  // Monitor: accumulate per-instruction behaviour, score it on each completion pulse.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      m_cyc++;
      m_ssig = {m_ssig[59:0], state};
      m_csig = {m_csig[57:0], iord, alusrc_a, alusrc_b, aluop};
      m_irw  += int'(ir_write);
      m_mrd  += int'(mem_read);
      m_mwr  += int'(mem_write);
      m_pcen += int'(pc_en);
      m_rw   += int'(regwrite);
      if (instr_done || illegal || m_cyc > 40) begin
        if (sbq.size() == 0) begin
          chk("unexpected_completion", 64'd1, 64'd0);
        end else begin
          m_e = sbq.pop_front();
          chk("cycles", 64'(m_cyc), 64'(m_e.cycles));
          chk("state_trace", m_ssig, m_e.ssig);
          chk("ctl_trace", m_csig, m_e.csig);
          chk("ir_write_cnt", 64'(m_irw), 64'(m_e.irw));
          chk("mem_read_cnt", 64'(m_mrd), 64'(m_e.mrd));
          chk("mem_write_cnt", 64'(m_mwr), 64'(m_e.mwr));
          chk("pc_en_cnt", 64'(m_pcen), 64'(m_e.pcen));
          chk("regwrite_cnt", 64'(m_rw), 64'(m_e.rw));
          chk("illegal", 64'(illegal), 64'(m_e.ill));
          chk("instr_done", 64'(instr_done), 64'(!m_e.ill));
          chk("regdst", 64'(regdst), 64'(m_e.regdst));
          chk("memtoreg", 64'(memtoreg), 64'(m_e.memtoreg));
          chk("pc_source", 64'(pc_source), 64'(m_e.pc_source));
        end
        m_cyc = 0; m_irw = 0; m_mrd = 0; m_mwr = 0; m_pcen = 0; m_rw = 0;
        m_ssig = 64'd0; m_csig = 64'd0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] legal_ops [7];
    logic [5:0] op;
    legal_ops = '{OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_BEQ, OP_JAL};

    // Reset held for two edges with memory ready: everything must stay quiet.
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; opcode = OP_SW;
    @(posedge clk); #1;
    chk("reset_outputs_1", 64'(all_out), 64'd0);
    @(posedge clk); #1;
    chk("reset_outputs_2", 64'(all_out), 64'd0);
    rst_n = 1'b1; #1;
    chk("post_reset_state", 64'(state), 64'd0);
    chk("post_reset_mem_read", 64'(mem_read), 64'd1);
    chk("post_reset_ir_write", 64'(ir_write), 64'd1);
    chk("post_reset_pc_en", 64'(pc_en), 64'd1);
    mon_en = 1'b1;

    // Directed instructions.
    run_instr(OP_RTYPE, 0, 0, 1'b0);
    run_instr(OP_LW, 2, 3, 1'b0);
    run_instr(OP_BEQ, 0, 0, 1'b1);
    run_instr(OP_BEQ, 0, 0, 1'b0);
    run_instr(OP_JAL, 0, 0, 1'b0);
    run_instr(6'b111111, 0, 0, 1'b0);
    run_instr(OP_SW, 1, 2, 1'b0);
    run_instr(OP_ADDI, 0, 0, 1'b0);
    run_instr(OP_ANDI, 1, 0, 1'b0);

    // Randomized mix, including arbitrary opcodes.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) != 0) op = legal_ops[$urandom_range(0, 6)];
      else                           op = 6'($urandom);
      run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    mon_en = 1'b0;
    chk("scoreboard_drain", 64'(sbq.size()), 64'd0);

    // Reset in the middle of a store wait must kill the write strobe immediately.
    opcode = OP_SW; mem_ready = 1'b1; zero = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0; #1;
    chk("memwr_entered", 64'({state, mem_write}), 64'({4'd5, 1'b1}));
    rst_n = 1'b0; #1;
    chk("reset_kills_mem_write", 64'(mem_write), 64'd0);
    chk("reset_mid_outputs", 64'(all_out), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    chk("reset_returns_fetch", 64'(state), 64'd0);
    chk("reset_fetch_mem_read", 64'({mem_read, mem_write, ir_write}), 64'(3'b100));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
